// File: rtl/mdr_in_seq_pkg.sv
// Shared types for the MDR unit: operation/data types, the input-sequencer
// state encoding and the default debounce length.
package pkg_system_mdr;

    localparam int OP_W           = 2;
    localparam int DATA_W         = 8;
    localparam int DEB_CYCLES_DEF = 4;

    typedef logic [OP_W-1:0]   op_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        IDLE_X = 2'd0,
        WAIT_Y = 2'd1,
        ARMED  = 2'd2,
        BUSY   = 2'd3
    } in_state_t;

endpackage

// File: rtl/mdr_in_seq_debounce.sv
// Button conditioner: two-flop synchroniser, optional debounce counter
// (enabled by MDR_IN_DEBOUNCE_EN) and a registered rising-edge press pulse.
module mdr_debounce
    import pkg_system_mdr::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    logic       sync1;
    logic       sync2;
    logic       level;
    logic       level_q;
    logic       primed;
    logic [1:0] warm;

    if (DEB_CYCLES < 1 || DEB_CYCLES > 255) begin : g_bad_cfg
        $error("mdr_debounce: DEB_CYCLES must be within 1..255");
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

`ifdef MDR_IN_DEBOUNCE_EN
    localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= 8'd0;
            level <= 1'b0;
        end else if (sync2 == level) begin
            cnt <= 8'd0;
        end else if (cnt == DEB_LAST) begin
            level <= ~level;
            cnt   <= 8'd0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end
`else
    assign level = sync2;
`endif

    // A button held through reset must be seen released (once the
    // synchroniser has refilled) before any press is reported.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            warm    <= 2'd0;
            primed  <= 1'b0;
            level_q <= 1'b0;
            press   <= 1'b0;
        end else begin
            if (warm != 2'd2) begin
                warm <= warm + 2'd1;
            end
            if (warm == 2'd2 && !sync2) begin
                primed <= 1'b1;
            end
            level_q <= level;
            press   <= primed & level & ~level_q;
        end
    end

endmodule

// File: rtl/mdr_in_seq.sv
// Front-end sequencer for the MDR unit: enforces load X, load Y, start, ready
// ordering and latches the op code. Debounce enabled by MDR_IN_DEBOUNCE_EN.
module mdr_in_seq
    import pkg_system_mdr::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_load,
    input  op_t        i_op,
    input  logic       i_ready,
    output logic       o_start,
    output logic       o_load,
    output op_t        o_op,
    output logic       o_busy,
    output logic [1:0] o_phase,
    output logic       o_reject
);

    in_state_t state;
    in_state_t next_state;
    logic      start_press;
    logic      load_press;
    logic      start_nxt;
    logic      load_nxt;
    logic      reject_nxt;

    mdr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
        .clk   (clk),
        .rst   (rst),
        .raw   (i_start),
        .press (start_press)
    );

    mdr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_load (
        .clk   (clk),
        .rst   (rst),
        .raw   (i_load),
        .press (load_press)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE_X;
            o_start  <= 1'b0;
            o_load   <= 1'b0;
            o_reject <= 1'b0;
            o_op     <= '0;
        end else begin
            state    <= next_state;
            o_start  <= start_nxt;
            o_load   <= load_nxt;
            o_reject <= reject_nxt;
            if (start_nxt) begin
                o_op <= i_op;
            end
        end
    end

    // Any press that is not the one legal event for the state collapses
    // into a single reject pulse.
    always_comb begin
        next_state = state;
        start_nxt  = 1'b0;
        load_nxt   = 1'b0;
        reject_nxt = 1'b0;
        case (state)
            IDLE_X, WAIT_Y: begin
                if (load_press) begin
                    load_nxt   = 1'b1;
                    reject_nxt = start_press;
                    next_state = (state == IDLE_X) ? WAIT_Y : ARMED;
                end else if (start_press) begin
                    reject_nxt = 1'b1;
                end
            end
            ARMED: begin
                if (start_press) begin
                    start_nxt  = 1'b1;
                    reject_nxt = load_press;
                    next_state = BUSY;
                end else if (load_press) begin
                    reject_nxt = 1'b1;
                end
            end
            BUSY: begin
                reject_nxt = start_press | load_press;
                if (i_ready) begin
                    next_state = IDLE_X;
                end
            end
            default: next_state = IDLE_X;
        endcase
    end

    assign o_busy  = (state == BUSY);
    assign o_phase = state;

endmodule
